// File: rtl/mem_access_unit.sv
// MEM-stage initiator for the 64-word data memory: byte/half/word loads and stores.
// Latency from acceptance: precheck error 1 cycle, load/word store 2, sub-word store 3.
// Backpressure: req_ready is high only in IDLE, and stall is high whenever a request is in flight.
//
// Ports:
//   clk, reset                      clock and asynchronous active-high reset
//   req_valid/req_ready             request handshake
//   req_we, req_size                store/load select and access size
//   req_unsigned, req_addr          zero-extend select and byte address
//   req_wdata                       right-justified store data
//   rsp_valid/rsp_rdata             one-cycle response pulse and extended load data
//   rsp_error/rsp_err_code          error flag and code (01 align/size, 10 range, 11 denied)
//   stall                           high while the unit is not idle
//   mem_we/mem_re/mem_addr/mem_wd   memory request, word-addressed
//   mem_rd/mem_access_valid         combinational read data and legality from the memory
//   load_count/store_count/fault_count  saturating perf counters
// Optional feature: define MAU_PERF_EN to build the perf counters; otherwise they read 0.
module mem_access_unit #(
   parameter int ADDR_W = 6
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [31:0]       req_addr,
   input  logic [31:0]       req_wdata,
   output logic              rsp_valid,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_error,
   output logic [1:0]        rsp_err_code,
   output logic              stall,
   output logic              mem_we,
   output logic              mem_re,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wd,
   input  logic [31:0]       mem_rd,
   input  logic              mem_access_valid,
   output logic [15:0]       load_count,
   output logic [15:0]       store_count,
   output logic [15:0]       fault_count
);

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WRITE, S_RESP} state_t;

   localparam logic [31:0] ADDR_LIMIT = 32'd1 << (ADDR_W + 2);

   state_t              r_state;
   logic                r_we;
   logic [1:0]          r_size;
   logic                r_unsigned;
   logic [1:0]          r_addr;      // only the lane offset is needed after acceptance
   logic [15:0]         r_wdata;     // sub-word store data; word stores use req_wdata directly
   logic                r_req_ready;
   logic                r_rsp_valid;
   logic [31:0]         r_rsp_rdata;
   logic                r_rsp_error;
   logic [1:0]          r_err_code;
   logic                r_mem_we;
   logic                r_mem_re;
   logic [ADDR_W-1:0]   r_mem_addr;
   logic [31:0]         r_mem_wd;

   logic [1:0]          w_pre_code;
   logic [7:0]          w_byte;
   logic [15:0]         w_half;
   logic [31:0]         w_load;
   logic [31:0]         w_merged;

   // Precheck on the incoming request, in priority order.
   always_comb begin
      w_pre_code = 2'b00;
      if (req_size == 2'b11)
         w_pre_code = 2'b01;
      else if ((req_size == 2'b01 && req_addr[0]) ||
               (req_size == 2'b10 && req_addr[1:0] != 2'b00))
         w_pre_code = 2'b01;
      else if (req_addr >= ADDR_LIMIT)
         w_pre_code = 2'b10;
   end

   // Lane select and extension of the word read during ACCESS (little-endian lanes).
   always_comb begin
      w_byte = mem_rd[{r_addr, 3'b000} +: 8];
      w_half = mem_rd[{r_addr[1], 4'b0000} +: 16];
      case (r_size)
         2'b00:   w_load = r_unsigned ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
         2'b01:   w_load = r_unsigned ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
         default: w_load = mem_rd;
      endcase
   end

   // Read-modify-write merge: replace the addressed lane of the word being read.
   always_comb begin
      w_merged = mem_rd;
      if (r_size == 2'b00)
         w_merged[{r_addr, 3'b000} +: 8] = r_wdata[7:0];
      else
         w_merged[{r_addr[1], 4'b0000} +: 16] = r_wdata;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_we        <= 1'b0;
         r_size      <= 2'b00;
         r_unsigned  <= 1'b0;
         r_addr      <= 2'b00;
         r_wdata     <= 16'd0;
         r_req_ready <= 1'b1;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= 32'd0;
         r_rsp_error <= 1'b0;
         r_err_code  <= 2'b00;
         r_mem_we    <= 1'b0;
         r_mem_re    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wd    <= 32'd0;
      end else begin
         // Response fields are only meaningful during RESP.
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= 32'd0;
         r_rsp_error <= 1'b0;
         r_err_code  <= 2'b00;
         case (r_state)
            S_IDLE: begin
               if (req_valid) begin
                  r_we        <= req_we;
                  r_size      <= req_size;
                  r_unsigned  <= req_unsigned;
                  r_addr      <= req_addr[1:0];
                  r_wdata     <= req_wdata[15:0];
                  r_req_ready <= 1'b0;
                  if (w_pre_code != 2'b00) begin
                     r_state     <= S_RESP;
                     r_rsp_valid <= 1'b1;
                     r_rsp_error <= 1'b1;
                     r_err_code  <= w_pre_code;
                  end else begin
                     r_state    <= S_ACCESS;
                     r_mem_addr <= req_addr[ADDR_W+1:2];
                     // Only a full-word store writes directly; everything else reads first.
                     if (req_we && req_size == 2'b10) begin
                        r_mem_we <= 1'b1;
                        r_mem_wd <= req_wdata;
                     end else begin
                        r_mem_re <= 1'b1;
                     end
                  end
               end
            end
            S_ACCESS: begin
               r_mem_we <= 1'b0;
               r_mem_re <= 1'b0;
               r_mem_wd <= 32'd0;
               if (mem_access_valid && r_we && r_size != 2'b10) begin
                  // Sub-word store: write back the merged word at the same address.
                  r_state  <= S_WRITE;
                  r_mem_we <= 1'b1;
                  r_mem_wd <= w_merged;
               end else begin
                  r_state     <= S_RESP;
                  r_mem_addr  <= '0;
                  r_rsp_valid <= 1'b1;
                  if (!mem_access_valid) begin
                     r_rsp_error <= 1'b1;
                     r_err_code  <= 2'b11;
                  end else if (!r_we) begin
                     r_rsp_rdata <= w_load;
                  end
               end
            end
            S_WRITE: begin
               r_mem_we    <= 1'b0;
               r_mem_wd    <= 32'd0;
               r_mem_addr  <= '0;
               r_state     <= S_RESP;
               r_rsp_valid <= 1'b1;
               if (!mem_access_valid) begin
                  r_rsp_error <= 1'b1;
                  r_err_code  <= 2'b11;
               end
            end
            S_RESP: begin
               r_state     <= S_IDLE;
               r_req_ready <= 1'b1;
            end
            default: begin
               r_state     <= S_IDLE;
               r_req_ready <= 1'b1;
            end
         endcase
      end
   end

   assign req_ready    = r_req_ready;
   assign rsp_valid    = r_rsp_valid;
   assign rsp_rdata    = r_rsp_rdata;
   assign rsp_error    = r_rsp_error;
   assign rsp_err_code = r_err_code;
   assign stall        = (r_state != S_IDLE);
   assign mem_we       = r_mem_we;
   assign mem_re       = r_mem_re;
   assign mem_addr     = r_mem_addr;
   assign mem_wd       = r_mem_wd;

`ifdef MAU_PERF_EN
   logic [15:0] r_load_count;
   logic [15:0] r_store_count;
   logic [15:0] r_fault_count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_load_count  <= 16'd0;
         r_store_count <= 16'd0;
         r_fault_count <= 16'd0;
      end else if (r_state == S_RESP) begin
         if (r_rsp_error) begin
            if (r_fault_count != 16'hFFFF) r_fault_count <= r_fault_count + 16'd1;
         end else if (r_we) begin
            if (r_store_count != 16'hFFFF) r_store_count <= r_store_count + 16'd1;
         end else begin
            if (r_load_count != 16'hFFFF) r_load_count <= r_load_count + 16'd1;
         end
      end
   end

   assign load_count  = r_load_count;
   assign store_count = r_store_count;
   assign fault_count = r_fault_count;
`else
   assign load_count  = 16'd0;
   assign store_count = 16'd0;
   assign fault_count = 16'd0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a 64-word memory model (word 4 protected).
// Latency counted in clock edges from the acceptance edge to rsp_valid.
// Requests are held until req_ready; every wait is bounded.
module tb_mem_access_unit;

   logic        clk;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_error;
   logic [1:0]  rsp_err_code;
   logic        stall;
   logic        mem_we;
   logic        mem_re;
   logic [5:0]  mem_addr;
   logic [31:0] mem_wd;
   logic [31:0] mem_rd;
   logic        mem_access_valid;
   logic [15:0] load_count;
   logic [15:0] store_count;
   logic [15:0] fault_count;

   mem_access_unit #(.ADDR_W(6)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
      .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
      .rsp_err_code(rsp_err_code), .stall(stall),
      .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr), .mem_wd(mem_wd),
      .mem_rd(mem_rd), .mem_access_valid(mem_access_valid),
      .load_count(load_count), .store_count(store_count), .fault_count(fault_count)
   );

   // Memory model: word 4 is protected.
   logic [31:0] ram [64];
   assign mem_rd           = ram[mem_addr];
   assign mem_access_valid = !((mem_we || mem_re) && mem_addr == 6'd4);

   initial begin
      for (int i = 0; i < 64; i++) ram[i] <= 32'd0;
      ram[4]  <= 32'h1234_5678;
      ram[20] <= 32'h0000_0005;
      ram[21] <= 32'h0000_000C;
      ram[63] <= 32'h8001_0000;
   end

   always @(posedge clk) begin
      if (mem_we && mem_access_valid) ram[mem_addr] <= mem_wd;
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int n_we_total  = 0;
   int n_rsp_total = 0;
   int n_both      = 0;

   always @(negedge clk) begin
      if (mem_we) n_we_total++;
      if (rsp_valid) n_rsp_total++;
      if (mem_we && mem_re) n_both++;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Results of the last transaction.
   int          t_cycles;
   int          t_re;
   int          t_we;
   logic [5:0]  t_re_addr;
   logic [5:0]  t_we_addr;
   logic [31:0] t_we_wd;
   logic [31:0] t_rdata;
   logic        t_err;
   logic [1:0]  t_code;

   task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd);
      int guard;
      @(negedge clk);
      req_valid    = 1'b1;
      req_we       = we;
      req_size     = size;
      req_unsigned = uns;
      req_addr     = addr;
      req_wdata    = wd;
      guard = 0;
      while (!req_ready && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      t_cycles = 1; t_re = 0; t_we = 0;
      t_re_addr = '0; t_we_addr = '0; t_we_wd = '0;
      while (!rsp_valid && t_cycles < 10) begin
         if (mem_re) begin t_re++; t_re_addr = mem_addr; end
         if (mem_we) begin t_we++; t_we_addr = mem_addr; t_we_wd = mem_wd; end
         @(posedge clk);
         #1;
         t_cycles++;
      end
      check_eq("rsp_seen", {31'd0, rsp_valid}, 32'd1);
      t_rdata = rsp_rdata;
      t_err   = rsp_error;
      t_code  = rsp_err_code;
      @(posedge clk);
      #1;
      check_eq("rsp_one_cycle", {31'd0, rsp_valid}, 32'd0);
   endtask

   task automatic expect_load(input string tag, input logic [31:0] exp_data);
      check_eq({tag, "_data"}, t_rdata, exp_data);
      check_eq({tag, "_err"}, {31'd0, t_err}, 32'd0);
   endtask

   task automatic expect_error(input string tag, input logic [1:0] code);
      check_eq({tag, "_code"}, {30'd0, t_code}, {30'd0, code});
      check_eq({tag, "_err"}, {31'd0, t_err}, 32'd1);
      check_eq({tag, "_rdata"}, t_rdata, 32'd0);
   endtask

   initial begin
      logic [15:0] f0;
      int we0;
      int rsp0;
      reset = 1'b1;
      req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
      req_addr = 32'd0; req_wdata = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_req_ready", {31'd0, req_ready}, 32'd1);
      check_eq("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check_eq("rst_stall", {31'd0, stall}, 32'd0);
      check_eq("rst_mem", {mem_we, mem_re, mem_addr, mem_wd[23:0]}, 32'd0);
      @(negedge clk);
      reset = 1'b0;

      // Word load from word 20.
      do_req(1'b0, 2'b10, 1'b0, 32'h50, 32'd0);
      expect_load("lw_50", 32'h0000_0005);
      check_eq("lw_50_lat", t_cycles, 2);
      check_eq("lw_50_re", t_re, 1);

      // Byte store to lane 2 of word 20: read then merged write.
      do_req(1'b1, 2'b00, 1'b0, 32'h52, 32'h0000_00AB);
      check_eq("sb_52_err", {31'd0, t_err}, 32'd0);
      check_eq("sb_52_lat", t_cycles, 3);
      check_eq("sb_52_re_addr", {26'd0, t_re_addr}, 32'd20);
      check_eq("sb_52_we_addr", {26'd0, t_we_addr}, 32'd20);
      check_eq("sb_52_wd", t_we_wd, 32'h00AB_0005);
      do_req(1'b0, 2'b10, 1'b0, 32'h50, 32'd0);
      expect_load("lw_50_after_sb", 32'h00AB_0005);

      // Word store, then sign/zero-extended sub-word loads.
      do_req(1'b1, 2'b10, 1'b0, 32'h58, 32'hFFFF_FF80);
      check_eq("sw_58_lat", t_cycles, 2);
      check_eq("sw_58_re", t_re, 0);
      check_eq("sw_58_wd", t_we_wd, 32'hFFFF_FF80);
      do_req(1'b0, 2'b00, 1'b0, 32'h58, 32'd0);
      expect_load("lb_58", 32'hFFFF_FF80);
      do_req(1'b0, 2'b00, 1'b1, 32'h58, 32'd0);
      expect_load("lbu_58", 32'h0000_0080);
      do_req(1'b0, 2'b01, 1'b0, 32'h5A, 32'd0);
      expect_load("lh_5a", 32'hFFFF_FFFF);

      // Top of the address range.
      do_req(1'b0, 2'b01, 1'b0, 32'hFE, 32'd0);
      expect_load("lh_fe", 32'hFFFF_8001);
      do_req(1'b0, 2'b01, 1'b1, 32'hFE, 32'd0);
      expect_load("lhu_fe", 32'h0000_8001);

      // Precheck errors.
      do_req(1'b0, 2'b01, 1'b0, 32'h51, 32'd0);
      expect_error("lh_51", 2'b01);
      check_eq("lh_51_lat", t_cycles, 1);
      check_eq("lh_51_mem", t_re + t_we, 0);
      do_req(1'b0, 2'b10, 1'b0, 32'h52, 32'd0);
      expect_error("lw_52", 2'b01);
      do_req(1'b0, 2'b11, 1'b0, 32'h50, 32'd0);
      expect_error("size_11", 2'b01);
      do_req(1'b0, 2'b10, 1'b0, 32'h100, 32'd0);
      expect_error("lw_100", 2'b10);
      check_eq("lw_100_lat", t_cycles, 1);

      // Memory-denied accesses to the protected word.
      f0 = fault_count;
      do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF);
      expect_error("sw_10", 2'b11);
      check_eq("sw_10_ram", ram[4], 32'h1234_5678);
`ifdef MAU_PERF_EN
      check_eq("fault_count_inc", {16'd0, fault_count}, {16'd0, f0 + 16'd1});
`else
      check_eq("perf_tied_off", {load_count, store_count | fault_count | f0}, 32'd0);
`endif
      do_req(1'b1, 2'b00, 1'b0, 32'h11, 32'h0000_0077);
      expect_error("sb_11", 2'b11);
      check_eq("sb_11_lat", t_cycles, 2);
      check_eq("sb_11_we", t_we, 0);
      check_eq("sb_11_ram", ram[4], 32'h1234_5678);

      // Reset during ACCESS of a sub-word store aborts it.
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
      req_addr = 32'h54; req_wdata = 32'h0000_0099;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      check_eq("abort_in_access", {30'd0, stall, mem_re}, 32'd3);
      we0  = n_we_total;
      rsp0 = n_rsp_total;
      #2;
      reset = 1'b1;
      #1;
      check_eq("abort_mem_drop", {30'd0, mem_we, mem_re}, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("abort_req_ready", {31'd0, req_ready}, 32'd1);
      check_eq("abort_no_we", n_we_total - we0, 0);
      check_eq("abort_no_rsp", n_rsp_total - rsp0, 0);
      check_eq("abort_ram", ram[21], 32'h0000_000C);

      check_eq("we_re_exclusive", n_both, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage initiator for the pipeline's 64-word data memory.
- Accepts byte/half/word load and store requests from the pipeline over a valid/ready handshake, and checks alignment and range.
- Drives the memory's we/re/addr/wd interface, performing read-modify-write for sub-word stores, and returns extended load data plus an error code.
- Asserts stall while a request is in flight.

Parameters:
- ADDR_W, 6: word-address width of the data memory; valid byte addresses are 0 .. 2^(ADDR_W+2)-1.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request (high only in IDLE)
- req_we  in  1  1=store, 0=load
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as misaligned)
- req_unsigned  in  1  zero-extend load data (lbu/lhu)
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  32  extended load data (0 for stores and errors)
- rsp_error  out  1  request failed
- rsp_err_code  out  2  00 none, 01 misaligned/bad size, 10 out of range, 11 denied by memory
- stall  out  1  high whenever state != IDLE
- mem_we  out  1  memory write enable
- mem_re  out  1  memory read enable
- mem_addr  out  ADDR_W  word address
- mem_wd  out  32  memory write data
- mem_rd  in  32  memory read data (combinational)
- mem_access_valid  in  1  memory reports current access legal
- load_count, store_count, fault_count  out  16 each  perf counters (see Optional Feature)

Behaviour:
- Reset: asynchronous, active-high. State=IDLE and all outputs 0, except req_ready=1. Registered request fields are cleared.
- A reset mid-operation aborts the access: mem_we/mem_re drop immediately and no rsp_valid is issued.
- States: IDLE, ACCESS, WRITE, RESP.
- Acceptance: req_valid && req_ready at a clock edge registers the request.
  - If any precheck fails, next state is RESP with the error latched. Prechecks, in priority order:
    - req_size==11 -> code 01
    - half with addr[0]!=0, or word with addr[1:0]!=0 -> code 01
    - req_addr >= 2^(ADDR_W+2) -> code 10
  - Otherwise next state is ACCESS.
- ACCESS:
  - mem_addr=addr[ADDR_W+1:2].
  - Load, or sub-word store: mem_re=1, mem_we=0. Capture mem_rd and mem_access_valid at the edge.
  - Word store: mem_we=1, mem_re=0, mem_wd=req_wdata. Capture mem_access_valid.
  - mem_we and mem_re are never both high.
  - Sub-word store with valid read -> WRITE. Everything else -> RESP.
- WRITE:
  - mem_we=1 with merged word: the captured word with the addressed byte lane (addr[1:0]) or half lane (addr[1]) replaced by req_wdata[7:0] / [15:0]. Lanes are little-endian.
  - Capture mem_access_valid, then go to RESP.
- RESP:
  - rsp_valid=1 for exactly one cycle.
  - rsp_error=1 iff code!=00. Code 11 if mem_access_valid was low in any memory cycle of this request.
  - Load rsp_rdata: selected lane, sign-extended unless req_unsigned; word passes through unchanged.
  - Next state is IDLE. A new request can be accepted the following cycle.
- Latency from acceptance edge to rsp_valid:
  - precheck error: 1 cycle
  - load or word store: 2 cycles
  - sub-word store: 3 cycles
  - A denied sub-word read skips WRITE (2 cycles).
- Outside ACCESS/WRITE: mem_we=mem_re=0, mem_addr=0, mem_wd=0.

Optional Feature:
- Macro: MAU_PERF_EN.
- When defined: in RESP, the unit increments load_count (successful load), store_count (successful store) or fault_count (any error). Counters saturate at 16'hFFFF and reset to 0.
- When undefined: the three outputs are tied to 0 and no counter registers are built.

Test Plan:
- Memory reset (RAM[20]=5, RAM[21]=0xC); word load at 0x50 -> rsp_valid 2 cycles after acceptance, rsp_rdata=0x00000005, rsp_error=0.
- Byte store 0xAB at 0x52 -> mem_re cycle at addr 20, then mem_we with mem_wd=0x00AB0005; a following word load at 0x50 returns 0x00AB0005.
- Word store 0xFFFFFF80 to 0x58, then lb at 0x58 -> 0xFFFFFF80; lbu at 0x58 -> 0x00000080; lh at 0x5A -> 0xFFFFFFFF.
- lh at 0x51 -> rsp_error=1, code 01, no mem_re/mem_we pulse, rsp_valid 1 cycle after acceptance; word load at 0x100 -> code 10.
- Word store to 0x10 (word 4, protected; memory drives mem_access_valid=0) -> code 11 and RAM[4] unchanged; with MAU_PERF_EN, fault_count increments by 1.
- Assert reset during the ACCESS state of a sub-word store -> mem_we never asserted, no rsp_valid, req_ready=1 after reset.
